port_link_receiver: RTL and testbench

PORT_LINK_RECEIVER -- requirements
Module: port_link_receiver

---
 rtl/port_link_receiver.sv | 143 ++++++++++++++
 tb/tb_port_link_receiver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/port_link_receiver.sv
// Reassembles 6-bit words from pairs of 3-bit toggle-strobed CPU symbols into a FWFT word FIFO; word visible 1 cycle after low symbol.
// Backpressure: a low symbol is withheld (no ack, timer frozen) while the FIFO is full and not being popped that cycle.
module port_link_receiver #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cpu_port_output,
    output logic [3:0] cpu_port_input,
    output logic [5:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err_timeout,
    input  logic       err_clear,
    output logic [2:0] fifo_count
);

    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE      = 1'b0,
        HAVE_HIGH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            last_tog_q, last_tog_d;
    logic [2:0]      hi_q, hi_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;

    logic [5:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [2:0]      count_q;
    logic [5:0]      last_head_q;

    logic            new_sym;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push;
    logic            stall;
    logic            timeout;
    logic [2:0]      sym;

    assign sym     = cpu_port_output[2:0];
    assign new_sym = cpu_port_output[3] != last_tog_q;
    assign full    = count_q == 3'(FIFO_DEPTH);
    assign empty   = count_q == 3'd0;
    assign pop     = !empty && rx_ready;
    // A pop in the same cycle frees a slot, so a full FIFO only stalls when nobody drains it.
    assign stall   = full && !pop;

    always_comb begin
        state_d    = state_q;
        last_tog_d = last_tog_q;
        hi_d       = hi_q;
        timer_d    = timer_q;
        push       = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (new_sym) begin
                    hi_d       = sym;
                    timer_d    = '0;
                    last_tog_d = cpu_port_output[3];
                    state_d    = HAVE_HIGH;
                end
            end
            HAVE_HIGH: begin
                if (new_sym) begin
                    if (!stall) begin
                        push       = 1'b1;
                        last_tog_d = cpu_port_output[3];
                        state_d    = IDLE;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    hi_d    = 3'd0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Timeout dominates a coincident clear so the event is never lost.
        err_d = timeout ? 1'b1 : (err_clear ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_tog_q <= 1'b0;
            hi_q       <= 3'd0;
            timer_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_tog_q <= last_tog_d;
            hi_q       <= hi_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {hi_q, sym};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= 3'd0;
            last_head_q <= 6'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                last_head_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // When empty, present the last word consumed so rx_data stays stable.
    assign rx_data        = empty ? last_head_q : mem[rd_ptr];
    assign rx_valid       = !empty;
    assign fifo_count     = count_q;
    assign err_timeout    = err_q;
    assign cpu_port_input = {last_tog_q, full, state_q == HAVE_HIGH, err_q};

endmodule

// File: tb/tb_port_link_receiver.sv
// Directed plus randomized bench for port_link_receiver against a queue-based reference model.
module tb_port_link_receiver;

    localparam int D = 4;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cpo;
    logic [3:0] cpi;
    logic [5:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       err_timeout;
    logic       err_clear;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    port_link_receiver #(.FIFO_DEPTH(D), .TIMEOUT(T)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cpu_port_output(cpo),
        .cpu_port_input(cpi),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .err_timeout(err_timeout),
        .err_clear(err_clear),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: words waiting for the consumer, plus the half-word in flight.
    logic [5:0] q[$];
    logic       m_tog;
    logic       m_have;
    logic [2:0] m_hi;
    int         m_idle;
    logic       m_err;
    logic [5:0] m_last_head;

    task automatic model_reset();
        q.delete();
        m_tog       = 1'b0;
        m_have      = 1'b0;
        m_hi        = 3'd0;
        m_idle      = 0;
        m_err       = 1'b0;
        m_last_head = 6'd0;
    endtask

    task automatic model_step();
        bit nw;
        bit popping;
        bit blocked;
        bit expired;
        nw      = cpo[3] != m_tog;
        popping = (q.size() != 0) && rx_ready;
        blocked = (q.size() == D) && !popping;
        expired = 1'b0;
        if (popping) m_last_head = q.pop_front();
        if (nw && !m_have) begin
            m_hi   = cpo[2:0];
            m_have = 1'b1;
            m_idle = 0;
            m_tog  = cpo[3];
        end else if (nw && m_have && !blocked) begin
            q.push_back({m_hi, cpo[2:0]});
            m_have = 1'b0;
            m_tog  = cpo[3];
        end else if (!nw && m_have) begin
            m_idle++;
            if (m_idle == T) begin
                m_have  = 1'b0;
                expired = 1'b1;
            end
        end
        if (expired) m_err = 1'b1;
        else if (err_clear) m_err = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_vec();
        logic [5:0] head;
        head = (q.size() != 0) ? q[0] : m_last_head;
        return {1'b0, m_tog, q.size() == D, m_have, m_err,
                q.size() != 0, head, 3'(q.size()), m_err};
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("cycle", {1'b0, cpi, rx_valid, rx_data, fifo_count, err_timeout}, model_vec());
    endtask

    task automatic send(input logic [2:0] s);
        cpo = {~cpo[3], s};
        cycle();
    endtask

    logic ack_exp;

    initial begin
        rst_n     = 1'b0;
        cpo       = 4'hF;
        rx_ready  = 1'b0;
        err_clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpi", {12'd0, cpi}, 16'h0);
        check("rst_valid", {15'd0, rx_valid}, 16'h0);
        check("rst_data", {10'd0, rx_data}, 16'h0);
        check("rst_count", {13'd0, fifo_count}, 16'h0);
        check("rst_err", {15'd0, err_timeout}, 16'h0);
        @(negedge clk) rst_n = 1'b1;
        cycle();
        check("rst_accept", {12'd0, cpi}, 16'b1010);

        cpo = 4'b0000; cycle();
        rx_ready = 1'b1; cycle(); rx_ready = 1'b0;

        cpo = 4'b1101; cycle();
        check("word_ack_hi", {15'd0, cpi[3]}, 16'd1);
        cpo = 4'b0011; cycle();
        check("word_data", {10'd0, rx_data}, 16'h2B);
        check("word_valid", {15'd0, rx_valid}, 16'd1);
        check("word_count", {13'd0, fifo_count}, 16'd1);
        check("word_ack_lo", {15'd0, cpi[3]}, 16'd0);

        repeat (3) begin
            send(3'($urandom_range(0, 7)));
            send(3'($urandom_range(0, 7)));
        end
        check("bp_full", {15'd0, cpi[2]}, 16'd1);
        check("bp_count", {13'd0, fifo_count}, 16'd4);
        send(3'($urandom_range(0, 7)));
        ack_exp = m_tog;
        send(3'($urandom_range(0, 7)));
        check("bp_ack_hold", {15'd0, cpi[3]}, {15'd0, ack_exp});
        check("bp_have_high", {15'd0, cpi[1]}, 16'd1);
        cycle();
        cycle();
        rx_ready = 1'b1; cycle(); rx_ready = 1'b0;
        check("bp_count_kept", {13'd0, fifo_count}, 16'd4);
        check("bp_accepted", {14'd0, cpi[3], cpi[1]}, {14'd0, ~ack_exp, 1'b0});
        rx_ready = 1'b1; repeat (5) cycle(); rx_ready = 1'b0;
        check("bp_drained", {13'd0, fifo_count}, 16'd0);

        send(3'd6);
        repeat (T - 1) cycle();
        check("to_pending", {14'd0, cpi[1:0]}, 16'b10);
        cycle();
        check("to_fired", {14'd0, cpi[1:0]}, 16'b01);
        check("to_no_push", {13'd0, fifo_count}, 16'd0);
        err_clear = 1'b1; cycle(); err_clear = 1'b0;
        check("to_clear", {15'd0, err_timeout}, 16'd0);

        send(3'd2);
        repeat (T - 1) cycle();
        send(3'd5);
        check("edge_push", {13'd0, fifo_count}, 16'd1);
        check("edge_data", {10'd0, rx_data}, 16'o25);
        check("edge_no_err", {15'd0, err_timeout}, 16'd0);

        send(3'd1);
        repeat (T - 1) cycle();
        err_clear = 1'b1; cycle(); err_clear = 1'b0;
        check("clr_vs_to", {15'd0, err_timeout}, 16'd1);
        err_clear = 1'b1; cycle(); err_clear = 1'b0;

        send(3'd4);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_count", {13'd0, fifo_count}, 16'd0);
        check("mid_rst_cpi", {12'd0, cpi}, 16'd0);
        model_reset();
        cpo = 4'b0000;
        @(negedge clk) rst_n = 1'b1;
        send(3'd5);
        check("mid_rst_high", {14'd0, cpi[1], rx_valid}, 16'b10);

        for (int i = 0; i < 600; i++) begin
            if ((i % 100) < 50) begin
                if ($urandom_range(0, 1) == 1) cpo = {~cpo[3], 3'($urandom_range(0, 7))};
            end else begin
                if ($urandom_range(0, 23) == 0) cpo = {~cpo[3], 3'($urandom_range(0, 7))};
            end
            rx_ready  = ($urandom_range(0, 2) == 0);
            err_clear = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
